// File: rtl/bloom_membership_query_if.sv
// Insert, query/response, clear and statistics signals of the bloom-filter
// query block. slave is the filter side, master is the requester/SoC side.
interface bloom_membership_query_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              ins_valid;
    logic              ins_ready;
    logic [DATA_W-1:0] ins_data;

    logic              q_valid;
    logic              q_ready;
    logic [DATA_W-1:0] q_data;

    logic              r_valid;
    logic              r_ready;
    logic              r_hit;
    logic [DATA_W-1:0] r_data;

    logic              clear_req;
    logic              clear_busy;

    logic [CNT_W-1:0]  distinct_count;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    modport slave (
        input  ins_valid, ins_data, q_valid, q_data, r_ready, clear_req,
        output ins_ready, q_ready, r_valid, r_hit, r_data, clear_busy,
        output distinct_count, hit_count, miss_count
    );

    modport master (
        output ins_valid, ins_data, q_valid, q_data, r_ready, clear_req,
        input  ins_ready, q_ready, r_valid, r_hit, r_data, clear_busy,
        input  distinct_count, hit_count, miss_count
    );
endinterface

// File: rtl/bloom_membership_query.sv
// Two-hash, M-bit bloom filter with an insert port, a 1-cycle query/response
// port, a sliced clear sweep and saturating insert/hit/miss statistics.
module bloom_membership_query #(
    parameter int DATA_W   = 8,
    parameter int M        = 256,
    parameter int CNT_W    = 16,
    parameter int CLR_BITS = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    bloom_membership_query_if.slave  bus
);

    localparam int NSLICE = M / CLR_BITS;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NSLICE - 1);
    localparam logic [DATA_W-1:0] H1_MASK  = DATA_W'(8'hA5);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    function automatic logic [DATA_W-1:0] hash0(input logic [DATA_W-1:0] d);
        return d;
    endfunction

    // Nibble swap then a fixed mask, so the two probes rarely coincide.
    function automatic logic [DATA_W-1:0] hash1(input logic [DATA_W-1:0] d);
        return {d[DATA_W/2-1:0], d[DATA_W-1:DATA_W/2]} ^ H1_MASK;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t            state_q,    state_d;
    logic [IDX_W-1:0]  idx_q,      idx_d;
    logic [M-1:0]      filter_q,   filter_d;
    logic              r_valid_q,  r_valid_d;
    logic              r_hit_q,    r_hit_d;
    logic [DATA_W-1:0] r_data_q,   r_data_d;
    logic [CNT_W-1:0]  distinct_q, distinct_d;
    logic [CNT_W-1:0]  hit_q,      hit_d;
    logic [CNT_W-1:0]  miss_q,     miss_d;

    logic              ins_ready;
    logic              q_ready;
    logic              ins_fire;
    logic              q_fire;
    logic [DATA_W-1:0] ins_h0, ins_h1;
    logic [DATA_W-1:0] q_h0,   q_h1;
    logic              ins_is_new;
    logic              q_is_hit;

    assign ins_h0 = hash0(bus.ins_data);
    assign ins_h1 = hash1(bus.ins_data);
    assign q_h0   = hash0(bus.q_data);
    assign q_h1   = hash1(bus.q_data);

    // Both lookups see the filter as it was before this edge, so a same-cycle
    // insert never shows up in a same-cycle query.
    assign ins_is_new = ~filter_q[ins_h0] | ~filter_q[ins_h1];
    assign q_is_hit   =  filter_q[q_h0]   &  filter_q[q_h1];

    // A clear request blocks both request ports in the very cycle it arrives.
    assign ins_ready = (state_q == S_IDLE) && !bus.clear_req;
    assign q_ready   = ins_ready && (!r_valid_q || bus.r_ready);
    assign ins_fire  = bus.ins_valid && ins_ready;
    assign q_fire    = bus.q_valid && q_ready;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        filter_d   = filter_q;
        r_valid_d  = r_valid_q;
        r_hit_d    = r_hit_q;
        r_data_d   = r_data_q;
        distinct_d = distinct_q;
        hit_d      = hit_q;
        miss_d     = miss_q;

        case (state_q)
            S_IDLE: begin
                if (bus.clear_req) begin
                    state_d    = S_CLEAR;
                    idx_d      = '0;
                    distinct_d = '0;
                    hit_d      = '0;
                    miss_d     = '0;
                end
            end
            S_CLEAR: begin
                for (int s = 0; s < NSLICE; s++) begin
                    if (idx_q == IDX_W'(s)) begin
                        filter_d[s*CLR_BITS +: CLR_BITS] = '0;
                    end
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (ins_fire) begin
            filter_d[ins_h0] = 1'b1;
            filter_d[ins_h1] = 1'b1;
            if (ins_is_new) begin
                distinct_d = sat_inc(distinct_q);
            end
        end

        // A new query reloads the response register in the same edge that
        // retires the previous one, giving one response per cycle.
        if (q_fire) begin
            r_valid_d = 1'b1;
            r_hit_d   = q_is_hit;
            r_data_d  = bus.q_data;
            if (q_is_hit) begin
                hit_d = sat_inc(hit_q);
            end else begin
                miss_d = sat_inc(miss_q);
            end
        end else if (r_valid_q && bus.r_ready) begin
            r_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            filter_q   <= '0;
            r_valid_q  <= 1'b0;
            r_hit_q    <= 1'b0;
            r_data_q   <= '0;
            distinct_q <= '0;
            hit_q      <= '0;
            miss_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            filter_q   <= filter_d;
            r_valid_q  <= r_valid_d;
            r_hit_q    <= r_hit_d;
            r_data_q   <= r_data_d;
            distinct_q <= distinct_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
        end
    end

    assign bus.ins_ready      = ins_ready;
    assign bus.q_ready        = q_ready;
    assign bus.r_valid        = r_valid_q;
    assign bus.r_hit          = r_hit_q;
    assign bus.r_data         = r_data_q;
    assign bus.clear_busy     = (state_q == S_CLEAR);
    assign bus.distinct_count = distinct_q;
    assign bus.hit_count      = hit_q;
    assign bus.miss_count     = miss_q;

endmodule

// File: tb/tb_bloom_membership_query.sv
// Directed bench for bloom_membership_query: a set-level reference model is
// compared every cycle, plus literal expectations at the interesting points.
module tb_bloom_membership_query;

    logic clk;
    logic reset_n;

    bloom_membership_query_if #(.DATA_W(8), .CNT_W(16)) bus ();

    bloom_membership_query #(
        .DATA_W  (8),
        .M       (256),
        .CNT_W   (16),
        .CLR_BITS(16)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [255:0] m_filter;
    int           m_clear_left;
    logic         m_rv;
    logic         m_rhit;
    logic [7:0]   m_rdata;
    int           m_dist, m_hit, m_miss;

    function automatic logic [7:0] h1f(input logic [7:0] d);
        return {d[3:0], d[7:4]} ^ 8'hA5;
    endfunction

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_reset();
        m_filter     = '0;
        m_clear_left = 0;
        m_rv         = 1'b0;
        m_rhit       = 1'b0;
        m_rdata      = 8'h00;
        m_dist       = 0;
        m_hit        = 0;
        m_miss       = 0;
    endtask

    function automatic logic exp_ins_rdy();
        return (m_clear_left == 0) && !bus.clear_req;
    endfunction

    function automatic logic exp_q_rdy();
        return exp_ins_rdy() && (!m_rv || bus.r_ready);
    endfunction

    task automatic model_compare();
        chk("ins_ready",  32'(bus.ins_ready),  32'(exp_ins_rdy()));
        chk("q_ready",    32'(bus.q_ready),    32'(exp_q_rdy()));
        chk("clear_busy", 32'(bus.clear_busy), 32'(m_clear_left > 0));
        chk("r_valid",    32'(bus.r_valid),    32'(m_rv));
        if (m_rv) begin
            chk("r_hit",  32'(bus.r_hit),  32'(m_rhit));
            chk("r_data", 32'(bus.r_data), 32'(m_rdata));
        end
        chk("distinct_count", 32'(bus.distinct_count), 32'(m_dist));
        chk("hit_count",      32'(bus.hit_count),      32'(m_hit));
        chk("miss_count",     32'(bus.miss_count),     32'(m_miss));
    endtask

    task automatic model_step();
        logic         ins_f, q_f;
        logic [255:0] old;
        logic [7:0]   d, bi;
        int           slice;
        ins_f = bus.ins_valid && exp_ins_rdy();
        q_f   = bus.q_valid && exp_q_rdy();
        old   = m_filter;
        if (m_clear_left > 0) begin
            slice = 16 - m_clear_left;
            for (int j = 0; j < 16; j++) begin
                bi = 8'(slice * 16 + j);
                m_filter[bi] = 1'b0;
            end
            m_clear_left--;
        end else if (bus.clear_req) begin
            m_clear_left = 16;
            m_dist = 0;
            m_hit  = 0;
            m_miss = 0;
        end
        if (ins_f) begin
            d = bus.ins_data;
            if (!old[d] || !old[h1f(d)]) m_dist = sat(m_dist);
            m_filter[d]      = 1'b1;
            m_filter[h1f(d)] = 1'b1;
        end
        if (q_f) begin
            d       = bus.q_data;
            m_rv    = 1'b1;
            m_rdata = d;
            m_rhit  = old[d] && old[h1f(d)];
            if (m_rhit) m_hit = sat(m_hit);
            else        m_miss = sat(m_miss);
        end else if (m_rv && bus.r_ready) begin
            m_rv = 1'b0;
        end
    endtask

    // Outputs are stable at the falling edge; inputs there are the ones the
    // next rising edge will act on.
    always @(negedge clk) begin
        if (!reset_n) begin
            model_reset();
            model_compare();
        end else begin
            model_compare();
            model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ins_valid = 1'b0;
        bus.ins_data  = 8'h00;
        bus.q_valid   = 1'b0;
        bus.q_data    = 8'h00;
        bus.r_ready   = 1'b1;
        bus.clear_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic do_insert(input logic [7:0] d);
        bus.ins_valid = 1'b1;
        bus.ins_data  = d;
        tick();
        bus.ins_valid = 1'b0;
    endtask

    task automatic do_query(input logic [7:0] d, input logic exp_hit, input string name);
        bus.q_valid = 1'b1;
        bus.q_data  = d;
        bus.r_ready = 1'b1;
        tick();
        bus.q_valid = 1'b0;
        chk({name, ".r_valid"}, 32'(bus.r_valid), 32'd1);
        chk({name, ".r_hit"},   32'(bus.r_hit),   32'(exp_hit));
        chk({name, ".r_data"},  32'(bus.r_data),  32'(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        chk("rst.r_valid",    32'(bus.r_valid),        32'd0);
        chk("rst.r_hit",      32'(bus.r_hit),          32'd0);
        chk("rst.r_data",     32'(bus.r_data),         32'd0);
        chk("rst.clear_busy", 32'(bus.clear_busy),     32'd0);
        chk("rst.distinct",   32'(bus.distinct_count), 32'd0);
        chk("rst.hits",       32'(bus.hit_count),      32'd0);
        chk("rst.misses",     32'(bus.miss_count),     32'd0);
        reset_n = 1'b1;

        // Empty filter: query 0x00 misses.
        tick();
        do_query(8'h00, 1'b0, "empty_q00");
        chk("empty.misses", 32'(bus.miss_count), 32'd1);
        chk("empty.hits",   32'(bus.hit_count),  32'd0);
        tick();

        // Insert 0x00 (bits 0x00, 0xA5); 0x12 probes 0x12 and 0x84.
        do_reset();
        do_insert(8'h00);
        do_query(8'h00, 1'b1, "q00");
        do_query(8'h12, 1'b0, "q12");
        chk("basic.distinct", 32'(bus.distinct_count), 32'd1);
        chk("basic.hits",     32'(bus.hit_count),      32'd1);
        chk("basic.misses",   32'(bus.miss_count),     32'd1);
        tick();

        // False positive: 0xB4 -> {B4,EE}, 0x4B -> {4B,11}; 0x11 probes {11,B4}.
        do_reset();
        do_insert(8'hB4);
        do_insert(8'h4B);
        do_query(8'h11, 1'b1, "fp_q11");
        chk("fp.distinct", 32'(bus.distinct_count), 32'd2);
        do_insert(8'hB4);
        chk("fp.reinsert_distinct", 32'(bus.distinct_count), 32'd2);
        tick();

        // Same-cycle insert and query of 0x33.
        do_reset();
        bus.ins_valid = 1'b1;
        bus.ins_data  = 8'h33;
        bus.q_valid   = 1'b1;
        bus.q_data    = 8'h33;
        tick();
        bus.ins_valid = 1'b0;
        bus.q_valid   = 1'b0;
        chk("same.r_hit",    32'(bus.r_hit),          32'd0);
        chk("same.distinct", 32'(bus.distinct_count), 32'd1);
        do_query(8'h33, 1'b1, "after_q33");
        tick();

        // Backpressure with two queued queries.
        do_reset();
        bus.r_ready = 1'b0;
        bus.q_valid = 1'b1;
        bus.q_data  = 8'h01;
        #1;
        chk("bp.q_ready_first", 32'(bus.q_ready), 32'd1);
        tick();
        bus.q_data = 8'h02;
        #1;
        chk("bp.q_ready_blocked", 32'(bus.q_ready), 32'd0);
        chk("bp.r_data_hold0",    32'(bus.r_data),  32'h01);
        tick();
        chk("bp.r_data_hold1", 32'(bus.r_data),  32'h01);
        chk("bp.r_valid_hold", 32'(bus.r_valid), 32'd1);
        bus.r_ready = 1'b1;
        #1;
        chk("bp.q_ready_release", 32'(bus.q_ready), 32'd1);
        tick();
        bus.q_valid = 1'b0;
        chk("bp.r_data_next", 32'(bus.r_data),     32'h02);
        chk("bp.misses",      32'(bus.miss_count), 32'd2);
        tick();

        // Clear sweep with a pending response and contending requests.
        do_reset();
        do_insert(8'h00);
        bus.r_ready = 1'b0;
        bus.q_valid = 1'b1;
        bus.q_data  = 8'h00;
        tick();
        bus.clear_req = 1'b1;
        bus.ins_valid = 1'b1;
        bus.ins_data  = 8'h77;
        #1;
        chk("clr.ins_ready_on_req", 32'(bus.ins_ready), 32'd0);
        chk("clr.q_ready_on_req",   32'(bus.q_ready),   32'd0);
        tick();
        bus.clear_req = 1'b0;
        chk("clr.pending_valid", 32'(bus.r_valid), 32'd1);
        chk("clr.pending_hit",   32'(bus.r_hit),   32'd1);
        for (int i = 0; i < 16; i++) begin
            if (i == 3) bus.r_ready = 1'b1;
            #1;
            chk("clr.busy",      32'(bus.clear_busy),     32'd1);
            chk("clr.ins_ready", 32'(bus.ins_ready),      32'd0);
            chk("clr.q_ready",   32'(bus.q_ready),        32'd0);
            chk("clr.distinct",  32'(bus.distinct_count), 32'd0);
            chk("clr.hits",      32'(bus.hit_count),      32'd0);
            tick();
        end
        bus.ins_valid = 1'b0;
        bus.q_valid   = 1'b0;
        chk("clr.busy_done", 32'(bus.clear_busy), 32'd0);
        tick();
        do_query(8'h00, 1'b0, "clr_q00");
        tick();

        // Reset in the middle of a sweep.
        do_insert(8'h55);
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("rst_mid.busy_before", 32'(bus.clear_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid.busy",    32'(bus.clear_busy), 32'd0);
        chk("rst_mid.r_valid", 32'(bus.r_valid),    32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        do_query(8'h55, 1'b0, "rst_mid_q55");
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
